// File: rtl/snake_step_ctrl.sv
// rtl/snake_step_ctrl.sv - game-step sequencer: frame pacing, direction latch, move handshake, score/speed
module snake_step_ctrl #(
  parameter int INIT_PERIOD   = 30,
  parameter int MIN_PERIOD    = 6,
  parameter int SPEEDUP_FOODS = 4,
  parameter int SPEEDUP_DEC   = 2,
  parameter int WIN_SCORE     = 99
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] game_state,
  input  logic       frame_start,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       move_ack,
  input  logic       hit_wall,
  input  logic       hit_food,
  output logic       move_req,
  output logic [1:0] dir,
  output logic       grow,
  output logic [7:0] score,
  output logic [5:0] period,
  output logic       game_won,
  output logic       game_over
);

  localparam logic [5:0] P_INIT  = 6'(INIT_PERIOD);
  localparam logic [6:0] P_MIN   = 7'(MIN_PERIOD);
  localparam logic [6:0] P_DEC   = 7'(SPEEDUP_DEC);
  localparam logic [7:0] S_WIN   = 8'(WIN_SCORE);
  localparam logic [7:0] F_SPEED = 8'(SPEEDUP_FOODS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EVAL} state_t;

  state_t     state, state_nxt;
  logic [1:0] next_dir;
  logic [5:0] frame_cnt;
  logic [7:0] food_cnt;
  logic       tick;
  logic       hit_wall_q, hit_food_q;
  logic       issue, capture, evaluate;

  // 00 and the undefined 10 both count as GAME_START
  logic rearm, in_game, halted;
  assign rearm   = ~game_state[0];
  assign in_game = (game_state == 2'b01);
  assign halted  = game_won | game_over;

  logic       key_valid;
  logic [1:0] key_code;
  logic       key_rev;
  always_comb begin
    key_valid = key_up | key_down | key_left | key_right;
    key_code  = 2'b11;
    if (key_up)        key_code = 2'b00;
    else if (key_down) key_code = 2'b01;
    else if (key_left) key_code = 2'b10;
    key_rev = (key_code[1] == dir[1]) && (key_code[0] != dir[0]);
  end

  logic frame_en, frame_wrap;
  assign frame_en   = in_game && !halted && frame_start;
  assign frame_wrap = frame_en && (frame_cnt >= period - 6'd1);

  logic [7:0] score_inc, food_inc;
  logic [5:0] period_dec;
  assign score_inc  = (score >= S_WIN) ? score : score + 8'd1;
  assign food_inc   = food_cnt + 8'd1;
  assign period_dec = ({1'b0, period} >= P_MIN + P_DEC) ? period - P_DEC[5:0] : P_MIN[5:0];

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  state <= S_IDLE;
    else if (rearm)  state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick && in_game && !halted) state_nxt = S_REQ;
      S_REQ:   if (!in_game) state_nxt = S_IDLE;
               else if (move_ack) state_nxt = S_EVAL;
      S_EVAL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    move_req = (state == S_REQ);
    issue    = (state == S_IDLE) && (state_nxt == S_REQ);
    capture  = (state == S_REQ) && (state_nxt == S_EVAL);
    evaluate = (state == S_EVAL);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dir        <= 2'b11;
      next_dir   <= 2'b11;
      grow       <= 1'b0;
      score      <= 8'd0;
      period     <= P_INIT;
      game_won   <= 1'b0;
      game_over  <= 1'b0;
      frame_cnt  <= 6'd0;
      food_cnt   <= 8'd0;
      tick       <= 1'b0;
      hit_wall_q <= 1'b0;
      hit_food_q <= 1'b0;
    end else if (rearm) begin
      dir        <= 2'b11;
      next_dir   <= 2'b11;
      grow       <= 1'b0;
      score      <= 8'd0;
      period     <= P_INIT;
      game_won   <= 1'b0;
      game_over  <= 1'b0;
      frame_cnt  <= 6'd0;
      food_cnt   <= 8'd0;
      tick       <= 1'b0;
      hit_wall_q <= 1'b0;
      hit_food_q <= 1'b0;
    end else begin
      grow <= 1'b0;
      if (in_game && key_valid && !key_rev) next_dir <= key_code;
      if (frame_en) frame_cnt <= frame_wrap ? 6'd0 : frame_cnt + 6'd1;
      // a fresh tick landing on the issue cycle is kept rather than lost
      if (frame_wrap)  tick <= 1'b1;
      else if (issue)  tick <= 1'b0;
      if (issue) dir <= next_dir;
      if (capture) begin
        hit_wall_q <= hit_wall;
        hit_food_q <= hit_food;
      end
      if (evaluate) begin
        if (hit_wall_q) begin
          game_over <= 1'b1;
        end else if (hit_food_q) begin
          grow  <= 1'b1;
          score <= score_inc;
          if (score_inc == S_WIN) game_won <= 1'b1;
          if (food_inc == F_SPEED) begin
            food_cnt <= 8'd0;
            period   <= period_dec;
          end else begin
            food_cnt <= food_inc;
          end
        end
      end
    end
  end

endmodule

// File: doc/snake_step_ctrl.md
# snake_step_ctrl

Game-step sequencer between the top-level game state machine and the snake/board datapath. While the game is running it counts VGA frames, latches the player's direction, and issues one move request per step period. It then consumes the datapath's collision result and maintains score and speed level. It raises the `game_won` / `game_over` levels that drive the game state machine out of its in-game state.

## Interface
Parameters:
- INIT_PERIOD, 30: frames per step at game start (range 2–63).
- MIN_PERIOD, 6: floor for the step period (at least 2, at most INIT_PERIOD).
- SPEEDUP_FOODS, 4: number of foods eaten per speed-up.
- SPEEDUP_DEC, 2: frames removed from the period at each speed-up.
- WIN_SCORE, 99: score at which the game is won (1–255).

Ports (reset `sys_rst_n` is asynchronous, active-low; clock is `vga_clk`):
- vga_clk, in, 1: system/pixel clock.
- sys_rst_n, in, 1: asynchronous active-low reset.
- game_state, in, 2: 00 GAME_START, 01 IN_GAME, 11 GAME_END; any other value is treated as GAME_START.
- frame_start, in, 1: one-cycle pulse per frame (start of vertical blank).
- key_up, key_down, key_left, key_right, in, 1 each: debounced key levels.
- move_ack, in, 1: datapath has finished the move; hit flags are valid in this cycle.
- hit_wall, in, 1: head hit a wall or the body; sampled only with move_ack.
- hit_food, in, 1: head ate food; sampled only with move_ack.
- move_req, out, 1: step request, held until acknowledged.
- dir, out, 2: 00 up, 01 down, 10 left, 11 right; stable while move_req is high.
- grow, out, 1: one-cycle pulse meaning "append a segment".
- score, out, 8: foods eaten, saturates at WIN_SCORE.
- period, out, 6: current frames per step (debug/HUD).
- game_won, out, 1: sticky level.
- game_over, out, 1: sticky level.

## Operation
- Reset values: move_req=0, dir=11, grow=0, score=0, period=INIT_PERIOD, game_won=0, game_over=0. The frame counter, food counter and pending tick are all 0, and the FSM is in IDLE.
- **Rearm:** on any cycle with game_state=GAME_START, restore every register to its reset value.
- **Direction latch:**
  - Active in every cycle with game_state=IN_GAME.
  - If more than one key is high, priority is up > down > left > right.
  - The chosen key is written to next_dir unless it is the reverse of the current dir. Reverse means the same upper bit and a different lower bit.
  - With no key pressed, next_dir holds its value.
  - dir takes next_dir only when a step is issued.
- **Frame counter:**
  - Counts frame_start pulses only while game_state=IN_GAME and neither game_won nor game_over is set.
  - When it reaches period-1 on a frame_start, it wraps to 0 and sets the one-deep pending tick.
  - A further tick while one is already pending is dropped.
- **Step FSM** (states IDLE, REQ, EVAL):
  - IDLE: if a tick is pending and the game is IN_GAME, clear the tick, set dir to next_dir, assert move_req, and go to REQ.
  - REQ: hold move_req until move_ack. Capture hit_wall and hit_food in the ack cycle, drop move_req, and go to EVAL.
  - EVAL: one cycle, then return to IDLE.
    - If hit_wall: set game_over. Score is not changed, even if hit_food is also set.
    - Else if hit_food: pulse grow, increment score (saturating at WIN_SCORE), and increment the food counter.
    - If the new score equals WIN_SCORE, set game_won.
    - When the food counter reaches SPEEDUP_FOODS, clear it and set period to max(period−SPEEDUP_DEC, MIN_PERIOD).
- **Abort:** if game_state leaves IN_GAME while in REQ, drop move_req on the next cycle, go to IDLE, and ignore any later move_ack.
- game_won and game_over hold through GAME_END and clear only on rearm. Once either is set, no further steps are issued.

## Timing
- Tick to move_req: the tick is set in the frame_start cycle, and move_req rises one cycle later (2 cycles after frame_start when the FSM is idle).
- move_ack in cycle N: move_req is low in N+1. In N+1 the EVAL decision is made, so grow, score, period, game_won and game_over show their new values from N+2.
- A move_ack arriving in the same cycle move_req first rises is accepted.
- The minimum gap between move_req assertions is period frames. Back-to-back steps need the pending tick, and at most one step can be queued.
- The direction keys can change next_dir every cycle. dir changes only on the cycle move_req rises.

## Test plan
- Reset, then game_state=01 with 30 frame_start pulses: move_req rises 2 cycles after the 30th pulse with dir=11. Ack with no hits: score stays 0 and grow stays 0.
- dir=11, press key_left then key_up before the next tick: the issued dir is 00. Pressing only key_left gives dir=11 (reverse rejected).
- Ack with hit_food=1 four times: score=4, four single-cycle grow pulses, and period goes from 30 to 28 after the 4th ack.
- Ack with hit_wall=1 and hit_food=1 together: game_over=1, score unchanged, grow=0, and no move_req on later frames.
- WIN_SCORE=3, three food acks: game_won=1 with score=3. Then game_state=11→00: all outputs return to reset values.
- During REQ, set game_state=11 and then raise move_ack: move_req falls the next cycle, and score, grow, game_over and game_won are unchanged.
